// File: rtl/uart_serial_core_pkg.sv
// Shared types and helpers for the uart_serial_core serial engine.
// State encodings for both FSMs and the baud divisor computation.
package uart_serial_core_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Clocks per bit, truncated; callers must keep the result >= 4.
    function automatic int unsigned baud_div(input int unsigned clkhz, input int unsigned baud);
        return clkhz / baud;
    endfunction

endpackage

// File: rtl/uart_serial_core_rx_sampler.sv
// 8N1 receive path: two-flop synchroniser, mid-bit sampling FSM and shifter.
// Emits the assembled byte and a one-cycle strobe when a valid stop bit is seen.
module uart_serial_core_rx_sampler
    import uart_serial_core_pkg::*;
#(
    parameter int unsigned DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       good_stop
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    logic [1:0]    sync;
    logic          rxs;
    rx_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bitn, bitn_nxt;
    logic [7:0]    shreg, shreg_nxt;

    assign rxs  = sync[1];
    assign data = shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '1;
            state <= RX_IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shreg <= '0;
        end else begin
            sync  <= {sync[0], rx};
            state <= state_nxt;
            cnt   <= cnt_nxt;
            bitn  <= bitn_nxt;
            shreg <= shreg_nxt;
        end
    end

    // Half-bit delay after the falling edge puts every later sample at mid-bit.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bitn_nxt  = bitn;
        shreg_nxt = shreg;
        good_stop = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rxs) begin
                    state_nxt = RX_START;
                    cnt_nxt   = HALF;
                end
            end
            RX_START: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (rxs) begin
                    state_nxt = RX_IDLE;
                end else begin
                    state_nxt = RX_DATA;
                    cnt_nxt   = FULL;
                    bitn_nxt  = '0;
                end
            end
            RX_DATA: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    shreg_nxt = {rxs, shreg[7:1]};
                    cnt_nxt   = FULL;
                    bitn_nxt  = bitn + 3'd1;
                    if (bitn == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (rxs) begin
                    good_stop = 1'b1;
                    state_nxt = RX_IDLE;
                end else begin
                    state_nxt = RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (rxs) state_nxt = RX_IDLE;
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_serial_core.sv
// Serial engine under the UART register front-end: 8N1 transmitter,
// receiver with one-byte holding register, and RTS flow control.
module uart_serial_core
    import uart_serial_core_pkg::*;
#(
    parameter int unsigned CLKHZ = 28000000,
    parameter int unsigned BAUD  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txdata,
    input  logic       txbegin,
    output logic       txbusy,
    output logic [7:0] rxdata,
    output logic       rxrecv,
    input  logic       data_read,
    input  logic       rx,
    output logic       tx,
    output logic       rts
);

    localparam int unsigned DIV = baud_div(CLKHZ, BAUD);
    localparam int unsigned CW  = $clog2(DIV);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    tx_state_t     tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_shreg, tx_shreg_nxt;

    logic          holding;
    logic          good_stop;
    logic [7:0]    rx_byte;

    uart_serial_core_rx_sampler #(
        .DIV(DIV)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (rx_byte),
        .good_stop(good_stop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shreg <= tx_shreg_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shreg_nxt = tx_shreg;
        tx           = 1'b1;
        txbusy       = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                txbusy = 1'b0;
                if (txbegin) begin
                    tx_state_nxt = TX_START;
                    tx_cnt_nxt   = FULL;
                    tx_shreg_nxt = txdata;
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (tx_cnt != '0) begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end else begin
                    tx_state_nxt = TX_DATA;
                    tx_cnt_nxt   = FULL;
                    tx_bit_nxt   = '0;
                end
            end
            TX_DATA: begin
                tx = tx_shreg[0];
                if (tx_cnt != '0) begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end else begin
                    tx_shreg_nxt = {1'b0, tx_shreg[7:1]};
                    tx_cnt_nxt   = FULL;
                    tx_bit_nxt   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt != '0) tx_cnt_nxt = tx_cnt - 1'b1;
                else              tx_state_nxt = TX_IDLE;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // A byte landing in the same cycle as a read keeps the register full.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxdata  <= '0;
            rxrecv  <= 1'b0;
            holding <= 1'b0;
        end else begin
            rxrecv <= good_stop;
            if (good_stop) begin
                rxdata  <= rx_byte;
                holding <= 1'b1;
            end else if (data_read) begin
                holding <= 1'b0;
            end
        end
    end

    assign rts = holding;

endmodule

// File: tb/tb_uart_serial_core.sv
// Directed plus randomized bench for uart_serial_core at DIV=16, checked
// against a frame-level model of the 8N1 line protocol.
module tb_uart_serial_core;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst, txbegin, data_read, rx_drv, loop_en;
    logic [7:0] txdata, rxdata;
    logic       txbusy, rxrecv, tx, rts, rx_line;

    int         checks = 0;
    int         errors = 0;
    int         pulse_cnt = 0;
    int         consec = 0;
    logic       prev_recv = 1'b0;
    logic [7:0] rx_q[$];

    int         n, lat, pc, w, busy, gap;
    logic [7:0] d, b, last_good;
    logic [7:0] lb[3];
    bit         hold;

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_serial_core #(
        .CLKHZ(1600000),
        .BAUD (100000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .txdata   (txdata),
        .txbegin  (txbegin),
        .txbusy   (txbusy),
        .rxdata   (rxdata),
        .rxrecv   (rxrecv),
        .data_read(data_read),
        .rx       (rx_line),
        .tx       (tx),
        .rts      (rts)
    );

    // Pulse monitor, sampled shortly after each edge.
    always @(posedge clk) begin
        #2;
        if (rxrecv === 1'b1) begin
            pulse_cnt++;
            rx_q.push_back(rxdata);
            if (prev_recv) consec++;
        end
        prev_recv = (rxrecv === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of bit i of an 8N1 frame: start, data LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] v, input int i);
        if (i <= 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return 1'((v >> (i - 1)) & 8'd1);
    endfunction

    task automatic send_tx(input logic [7:0] v);
        int bad;
        int bc;
        @(negedge clk);
        txdata  = v;
        txbegin = 1'b1;
        @(negedge clk);
        txbegin = 1'b0;
        txdata  = 8'($urandom);
        bad = 0;
        bc  = 0;
        for (int c = 0; c < 10 * DIV; c++) begin
            if (txbusy === 1'b1) bc++;
            if (tx !== frame_bit(v, c / DIV)) bad++;
            @(negedge clk);
        end
        chk("tx_frame_bad_cycles", bad, 0);
        chk("txbusy_len", bc, 10 * DIV);
        chk("txbusy_fall", txbusy, 0);
        chk("tx_idle_after", tx, 1);
    endtask

    task automatic send_rx(input logic [7:0] v, input int stop_low, input bit hold_read,
                           output int np, output logic [7:0] dv, output int lt);
        np = 0;
        dv = '0;
        lt = -1;
        for (int c = 0; c < 10 * DIV + stop_low + 30; c++) begin
            if (c < 9 * DIV)                 rx_drv = frame_bit(v, c / DIV);
            else if (c < 9 * DIV + stop_low) rx_drv = 1'b0;
            else                             rx_drv = 1'b1;
            data_read = hold_read && (np == 0) && (c >= 140);
            @(negedge clk);
            if (rxrecv === 1'b1) begin
                np++;
                dv = rxdata;
                if (lt < 0) lt = c + 1;
            end
        end
        data_read = 1'b0;
    endtask

    initial begin
        rst = 1'b1; txbegin = 1'b0; txdata = '0; data_read = 1'b0;
        rx_drv = 1'b1; loop_en = 1'b0; last_good = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_txbusy", txbusy, 0);
        chk("rst_rxdata", rxdata, 0);
        chk("rst_rxrecv", rxrecv, 0);
        chk("rst_rts", rts, 0);
        rst = 1'b0;

        // Transmit: directed A5 then random bytes
        send_tx(8'hA5);
        for (int i = 0; i < 4; i++) send_tx(8'($urandom));

        // Receive 3C, check holding and RTS release
        send_rx(8'h3C, 0, 1'b0, n, d, lat);
        last_good = 8'h3C;
        chk("rx3c_pulses", n, 1);
        chk("rx3c_data", d, 8'h3C);
        chk("rx3c_latency_ok", (lat >= 148 && lat <= 160), 1);
        repeat (10) @(negedge clk);
        chk("rx3c_rts_held", rts, 1);
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
        chk("rx3c_rts_release", rts, 0);

        // Short glitch must not produce a byte
        pc = pulse_cnt;
        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_no_pulse", pulse_cnt, pc);
        chk("glitch_rxdata", rxdata, last_good);
        send_rx(8'h01, 0, 1'b0, n, d, lat);
        last_good = 8'h01;
        chk("after_glitch_pulses", n, 1);
        chk("after_glitch_data", d, 8'h01);

        // Framing error: stop bit low for 40 clocks
        send_rx(8'hFF, 40, 1'b0, n, d, lat);
        chk("framing_no_pulse", n, 0);
        chk("framing_rxdata_kept", rxdata, last_good);
        send_rx(8'h55, 0, 1'b0, n, d, lat);
        last_good = 8'h55;
        chk("after_framing_pulses", n, 1);
        chk("after_framing_data", d, 8'h55);

        // Random receive, with overrun and read-collision cases mixed in
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            hold = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send_rx(b, 0, hold, n, d, lat);
            last_good = b;
            chk("rnd_rx_pulses", n, 1);
            chk("rnd_rx_data", d, b);
            chk("rnd_rx_rxdata", rxdata, b);
            chk("rnd_rx_latency_ok", (lat >= 148 && lat <= 160), 1);
            chk("rnd_rx_rts_full", rts, 1);
            if ($urandom_range(0, 1) == 1 && i < 5) begin
                data_read = 1'b1;
                @(negedge clk);
                data_read = 1'b0;
                chk("rnd_rx_rts_clear", rts, 0);
            end
        end

        // Reset mid-frame: TX in data bit 4, RX in data bit 3
        chk("pre_rst_rts", rts, 1);
        @(negedge clk);
        txdata  = 8'hC3;
        txbegin = 1'b1;
        for (int c = 0; c < 88; c++) begin
            if (c == 1) txbegin = 1'b0;
            rx_drv = (c >= 16 && c < 16 + 9 * DIV) ? frame_bit(8'hB7, (c - 16) / DIV) : 1'b1;
            @(negedge clk);
        end
        chk("mid_txbusy_before_rst", txbusy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_drv = 1'b1;
        chk("midrst_tx", tx, 1);
        chk("midrst_txbusy", txbusy, 0);
        chk("midrst_rts", rts, 0);
        chk("midrst_rxdata", rxdata, 0);
        pc = pulse_cnt;
        repeat (300) @(negedge clk);
        chk("midrst_no_partial_pulse", pulse_cnt, pc);
        chk("midrst_tx_stays_idle", tx, 1);

        // Loopback, txbegin held across three frames
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h81;
        @(negedge clk);
        rx_q.delete();
        loop_en = 1'b1;
        txdata  = lb[0];
        txbegin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w = 0;
            while (txbusy !== 1'b1 && w < 400) begin
                @(negedge clk);
                w++;
            end
            chk("lb_accept_in_time", (w < 400), 1);
            if (k < 2) txdata = lb[k + 1];
            else       txbegin = 1'b0;
            busy = 0;
            while (txbusy === 1'b1 && busy < 400) begin
                @(negedge clk);
                busy++;
            end
            chk("lb_busy_len", busy, 10 * DIV);
            if (k < 2) begin
                gap = 0;
                while (txbusy !== 1'b1 && gap < 20) begin
                    @(negedge clk);
                    gap++;
                end
                chk("lb_idle_gap", gap, 1);
            end
        end
        repeat (60) @(negedge clk);
        chk("lb_frames", rx_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < rx_q.size()) chk("lb_data", rx_q[i], lb[i]);
        end
        chk("lb_rxdata_last", rxdata, 8'h81);
        loop_en = 1'b0;
        chk("rxrecv_never_back_to_back", consec, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
